// File: rtl/shft_rx.sv
// shft_rx: serial-in/parallel-out receiver with a valid/ack holding register and sticky overrun flag
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   din   - serial data bit, sampled when en=1
//   en    - bit strobe
//   dir   - bit order (1 = LSB first, 0 = MSB first), latched with the first bit of a word
//   clr   - synchronous clear of the partial word and ovr (dout/valid untouched)
//   ack   - consumer accepts dout while valid=1
//   dout  - last completed word
//   valid - dout holds an unconsumed word
//   busy  - a partial word is in progress
//   ovr   - sticky flag: a completed word was dropped
module shft_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             ovr
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [WIDTH-1:0] sr_q, sr_d, sr_sh, dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d, valid_q, valid_d, ovr_q, ovr_d, busy_q;
    logic             smp, ord, done, load;
    always_comb begin
        smp     = en && !clr;
        // the first bit of a word uses the live dir input, later bits the latched order
        ord     = (cnt_q == '0) ? dir : dir_q;
        sr_sh   = ord ? {din, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], din};
        done    = smp && cnt_q == LAST;
        // holding register is free if empty or being drained this cycle
        load    = done && (!valid_q || ack);
        cnt_d   = clr ? '0 : !en ? cnt_q : done ? '0 : cnt_q + 1'b1;
        sr_d    = clr ? '0 : en ? sr_sh : sr_q;
        dir_d   = (smp && cnt_q == '0) ? dir : dir_q;
        dout_d  = load ? sr_sh : dout_q;
        valid_d = load ? 1'b1 : ack ? 1'b0 : valid_q;
        ovr_d   = clr ? 1'b0 : (done && !load) ? 1'b1 : ovr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            busy_q  <= cnt_d != '0;
        end
    end
    assign dout  = dout_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign ovr   = ovr_q;
endmodule

// File: tb/tb_shft_rx.sv
// tb_shft_rx: scoreboard bench for shft_rx (WIDTH=8)
module tb_shft_rx;
    logic       clk = 0, rst = 1, din = 0, en = 0, dir = 1, clr = 0, ack = 0;
    logic [7:0] dout;
    logic       valid, busy, ovr;
    int         n_chk = 0, n_err = 0;
    logic [7:0] exp_q[$];
    time        t_done, t1;
    always #5 clk = ~clk;
    shft_rx #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .dir(dir), .clr(clr), .ack(ack),
        .dout(dout), .valid(valid), .busy(busy), .ovr(ovr)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ack_cyc();
        en = 0;
        ack = 1;
        tick();
        ack = 0;
    endtask
    // send the first n bits of w in order dr; the 8th bit pops the scoreboard
    task automatic send(input logic [7:0] w, input logic dr, input int n, input bit gaps,
                        input bit tog, input bit ack_last);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    en = 0;
                    ack = 0;
                    tick();
                    check("gap_busy", busy, i != 0);
                end
            en = 1;
            din = dr ? w[i] : w[7-i];
            dir = (tog && i >= 3) ? ~dr : dr;
            ack = ack_last && i == n - 1;
            tick();
            ack = 0;
            check("busy", busy, i != 7);
            if (i == 7) begin
                t_done = $time;
                e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
                check("sb_dout", dout, e);
                check("sb_valid", valid, 1);
            end
        end
    endtask
    initial begin
        #12;
        check("rst_dout", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        rst = 0;
        exp_q.push_back(8'hA9);
        send(8'hA9, 1, 8, 0, 0, 0);
        ack_cyc();
        check("ack_valid", valid, 0);
        check("ack_dout", dout, 8'hA9);
        exp_q.push_back(8'h56);
        send(8'h56, 0, 8, 1, 1, 0);
        ack_cyc();
        exp_q.push_back(8'h11);
        send(8'h11, 1, 8, 0, 0, 0);
        check("ovr_pre", ovr, 0);
        exp_q.push_back(8'h11);
        send(8'h22, 1, 8, 0, 0, 0);
        check("ovr_set", ovr, 1);
        ack_cyc();
        check("ovr_ack_valid", valid, 0);
        check("ovr_sticky", ovr, 1);
        en = 0;
        clr = 1;
        tick();
        clr = 0;
        check("ovr_clr", ovr, 0);
        exp_q.push_back(8'h33);
        send(8'h33, 1, 8, 0, 0, 0);
        exp_q.push_back(8'hCC);
        send(8'hCC, 0, 8, 0, 0, 1);
        check("sim_ovr", ovr, 0);
        send(8'h5A, 1, 5, 0, 0, 0);
        #2 rst = 1;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ovr", ovr, 0);
        #1 rst = 0;
        exp_q.push_back(8'hA9);
        send(8'hA9, 1, 8, 0, 0, 0);
        send(8'h5A, 1, 5, 0, 0, 0);
        en = 1;
        din = 1;
        clr = 1;
        tick();
        clr = 0;
        en = 0;
        check("clr_busy", busy, 0);
        check("clr_dout", dout, 8'hA9);
        check("clr_valid", valid, 1);
        ack_cyc();
        exp_q.push_back(8'hA9);
        send(8'hA9, 1, 8, 0, 0, 0);
        ack_cyc();
        exp_q.push_back(8'hFF);
        send(8'hFF, 1, 8, 0, 0, 1);
        t1 = t_done;
        exp_q.push_back(8'h00);
        send(8'h00, 1, 8, 0, 0, 1);
        check("b2b_gap", 32'(t_done - t1), 80);
        check("b2b_ovr", ovr, 0);
        ack_cyc();
        check("b2b_valid", valid, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
